// File: rtl/register_file_16x32_pkg.sv
// Shared constants for the 16 x 32 ARM register file.
package register_file_16x32_pkg;

   localparam int REG_ADDR_W     = 4;
   localparam int REG_COUNT      = 16;
   localparam int PC_IDX         = 15;
   localparam int DATA_W_DEFAULT = 32;

   localparam int SP = 13;
   localparam int LR = 14;
   localparam int PC = 15;

   localparam logic [REG_ADDR_W-1:0] PC_ADDR = REG_ADDR_W'(PC_IDX);

   function automatic logic is_pc(input logic [REG_ADDR_W-1:0] a);
      return a == PC_ADDR;
   endfunction

endpackage

// File: rtl/register_file_16x32_decoder.sv
// Existing 4-to-16 one-hot address decoder.
module decoder_4x16
   import register_file_16x32_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] addr,
   output logic [REG_COUNT-1:0]  sel
);

   always_comb begin
      sel       = '0;
      sel[addr] = 1'b1;
   end

endmodule

// File: rtl/register_file_16x32.sv
// ARM R0-R15 register file: 3 combinational reads, 1 write,
// R15 doubles as PC with its own load port.
module register_file_16x32
   import register_file_16x32_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter bit BYPASS = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] ra_a,
   input  logic [REG_ADDR_W-1:0] ra_b,
   input  logic [REG_ADDR_W-1:0] ra_c,
   output logic [DATA_W-1:0]     rd_a,
   output logic [DATA_W-1:0]     rd_b,
   output logic [DATA_W-1:0]     rd_c,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0]     wd,
   input  logic                  pc_ld,
   input  logic [DATA_W-1:0]     pc_in,
   output logic [DATA_W-1:0]     pc_out
);

   logic [DATA_W-1:0]     regs [REG_COUNT];
   logic [REG_COUNT-1:0]  dec;
   logic [REG_COUNT-1:0]  wen;
   logic [REG_ADDR_W-1:0] ra [3];

   decoder_4x16 u_dec (
      .addr (wa),
      .sel  (dec)
   );

   assign wen = dec & {REG_COUNT{we}};

   // pc_ld is assigned last so it wins over a same-cycle write to R15
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < REG_COUNT; i++) begin
            if (wen[i]) regs[i] <= wd;
         end
         if (pc_ld) regs[PC_IDX] <= pc_in;
      end
   end

   assign ra[0] = ra_a;
   assign ra[1] = ra_b;
   assign ra[2] = ra_c;

   for (genvar p = 0; p < 3; p++) begin : g_rd
      logic [DATA_W-1:0] v;
      always_comb begin
         v = regs[ra[p]];
         if (BYPASS) begin
            if (pc_ld && is_pc(ra[p]))  v = pc_in;
            else if (we && ra[p] == wa) v = wd;
         end
      end
   end

   assign rd_a   = g_rd[0].v;
   assign rd_b   = g_rd[1].v;
   assign rd_c   = g_rd[2].v;
   assign pc_out = regs[PC_IDX];

endmodule

// File: doc/register_file_16x32.md
Name: register_file_16x32

Overview:
- 16 x 32-bit ARM general register file (R0-R15) that consumes the one-hot write-enable vector produced by the 4-to-16 write-address decoder.
- Three combinational read ports serve operand A, operand B and store-data/shift-amount.
- One synchronous write port serves writeback.
- R15 doubles as the program counter, with a dedicated load port and a continuous PC output for fetch.

Parameters:
- DATA_W, 32, width of each register.
- BYPASS, 1, 1 = a read port whose address matches the active write returns write data in the same cycle; 0 = it returns the stored value.

Ports:
- clk  in  1  single system clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- ra_a  in  4  read address, port A
- ra_b  in  4  read address, port B
- ra_c  in  4  read address, port C
- rd_a  out  DATA_W  read data, port A
- rd_b  out  DATA_W  read data, port B
- rd_c  out  DATA_W  read data, port C
- we  in  1  register write enable
- wa  in  4  write address, fed to the decoder
- wd  in  DATA_W  write data
- pc_ld  in  1  load R15 from pc_in
- pc_in  in  DATA_W  next PC value
- pc_out  out  DATA_W  current R15 contents, continuous

Behaviour:
- Reset: on a rising clk edge with rst_n=0, all 16 registers clear to 0.
  - Reset overrides we and pc_ld in the same cycle.
  - Following reset, pc_out=0 and rd_a/rd_b/rd_c=0 for any address.
  - Reset asserted mid-operation discards any write in that cycle.
- Write path:
  - wa drives the 4-to-16 decoder; each decoder output is ANDed with we to form per-register enables.
  - Exactly zero or one enable is active per cycle.
  - Register wa takes wd at the rising edge when we=1; latency 1 cycle.
- PC path:
  - pc_ld=1 loads pc_in into R15 at the rising edge.
  - If pc_ld=1 and a write (we=1, wa=15) occur in the same cycle, pc_ld wins and wd is dropped.
  - pc_ld=1 concurrent with a write to any other register: both updates take effect.
- Read path:
  - Purely combinational from the addressed register; no read latency.
  - With BYPASS=1, each port independently selects the write value when all of the following hold:
    - we=1 and ra_x==wa, or ra_x==15 with pc_ld=1.
    - The selected value follows the same priority as the write (pc_in over wd for R15).
  - With BYPASS=0, reads always reflect pre-edge contents.
  - Any number of ports may read the same register simultaneously.
- pc_out always shows stored R15; it is never bypassed.
- No undefined states: all 16 addresses are valid, so there is no out-of-range handling.
- Width: all data paths are DATA_W; no arithmetic inside the block (PC increment is external).

Decomposition:
- Shared package holds:
  - REG_ADDR_W=4
  - REG_COUNT=16
  - PC_IDX=15
  - DATA_W default 32
  - named register indices SP=13, LR=14, PC=15
- Sub-module: decoder_4x16 (existing 4-to-16 decoder), instantiated once for write-enable generation.
- Read muxes and bypass logic stay inline.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with we=1, wa=3, wd=32'hDEADBEEF -> after release, all ports read 0 at every address and pc_out=0.
- Write sweep: write R0..R14 with values 32'h1000_0000+i, one per cycle -> each reads back on ra_a/ra_b/ra_c with the matching value; no other register changes, checked via a full 16-address scan after each write.
- PC priority: same cycle we=1, wa=15, wd=32'h0000_0040, pc_ld=1, pc_in=32'h0000_0080 -> next cycle pc_out=32'h80 and rd_a(ra_a=15)=32'h80.
- Bypass (BYPASS=1): R5=32'h11111111; then we=1, wa=5, wd=32'h22222222, ra_b=5 -> rd_b=32'h22222222 in the same cycle. Rerun with BYPASS=0 -> rd_b=32'h11111111 in the same cycle and 32'h22222222 in the next.
- we=0 guard: wa cycles 0..15 with wd=32'hFFFFFFFF and we=0 -> no register changes.
- Mid-run reset: after loading R7=32'hCAFEF00D and pc_out=32'h100, assert rst_n=0 for 1 cycle concurrent with pc_ld=1 -> R7=0 and pc_out=0.
